// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: issues one data-memory access per EX/MEM instruction, stalls upstream while it is outstanding.
// Writeback results are registered (1 cycle after accept/response); request payload is held stable under dmem_req_ready backpressure.
module mem_stage_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  input  logic                      ex_is_load,
  input  logic                      ex_is_store,
  input  logic [1:0]                ex_size,
  input  logic                      ex_unsigned,
  input  logic [DATA_WIDTH-1:0]     ex_alu_res,
  input  logic [DATA_WIDTH-1:0]     ex_val_b,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      flush,
  output logic                      exmem_stall,
  output logic                      dmem_req_valid,
  input  logic                      dmem_req_ready,
  output logic                      dmem_req_we,
  output logic [DATA_WIDTH-1:0]     dmem_req_addr,
  output logic [DATA_WIDTH-1:0]     dmem_req_wdata,
  output logic [1:0]                dmem_req_size,
  input  logic                      dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0]     dmem_resp_data,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      wb_exc
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t                    state_q, state_d;
  logic                      kill_q, kill_d;
  logic                      we_q, we_d;
  logic [DATA_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [1:0]                size_q, size_d;
  logic                      uns_q, uns_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      wb_valid_q, wb_valid_d;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic                      wb_exc_q, wb_exc_d;
  logic                      stall_c;
  logic                      mem_op;
  logic                      misaligned;
  logic [DATA_WIDTH-1:0]     load_ext;

  assign mem_op = ex_is_load | ex_is_store;

  always_comb begin
    misaligned = 1'b0;
    case (ex_size)
      2'd1:    misaligned = ex_alu_res[0];
      2'd2:    misaligned = |ex_alu_res[1:0];
      2'd3:    misaligned = |ex_alu_res[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    load_ext = dmem_resp_data;
    case (size_q)
      2'd0: load_ext = {{(DATA_WIDTH-8){~uns_q & dmem_resp_data[7]}}, dmem_resp_data[7:0]};
      2'd1: load_ext = {{(DATA_WIDTH-16){~uns_q & dmem_resp_data[15]}}, dmem_resp_data[15:0]};
      2'd2: load_ext = {{(DATA_WIDTH-32){~uns_q & dmem_resp_data[31]}}, dmem_resp_data[31:0]};
      default: load_ext = dmem_resp_data;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_exc_d   = wb_exc_q;
    stall_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_valid && !flush) begin
          if (!mem_op || misaligned) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_alu_res;
            wb_exc_d   = mem_op;
          end else begin
            stall_c = 1'b1;
            state_d = S_REQ;
            we_d    = ex_is_store;
            addr_d  = ex_alu_res;
            wdata_d = ex_val_b;
            size_d  = ex_size;
            uns_d   = ex_unsigned;
            rd_d    = ex_rd;
          end
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        if (dmem_req_ready) begin
          state_d = (kill_q || flush) ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        // The response cycle releases the stall so EX/MEM advances on the same edge.
        stall_c = ~dmem_resp_valid;
        if (dmem_resp_valid) begin
          state_d = S_IDLE;
          if (!flush) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = we_q ? '0 : rd_q;
            wb_data_d  = we_q ? '0 : load_ext;
            wb_exc_d   = 1'b0;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        stall_c = 1'b1;
        if (dmem_resp_valid) begin
          kill_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      kill_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_exc_q   <= wb_exc_d;
    end
  end

  // Stall is combinational from ex_* in IDLE, so it is gated to read 0 while reset is held.
  assign exmem_stall    = stall_c & reset;
  assign dmem_req_valid = (state_q == S_REQ);
  assign dmem_req_we    = we_q;
  assign dmem_req_addr  = addr_q;
  assign dmem_req_wdata = wdata_q;
  assign dmem_req_size  = size_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign wb_exc         = wb_exc_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a writeback scoreboard queue.
module tb_mem_stage_ctrl;

  localparam int DW = 64;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid, ex_is_load, ex_is_store, ex_unsigned, flush;
  logic [1:0]    ex_size;
  logic [DW-1:0] ex_alu_res, ex_val_b;
  logic [RW-1:0] ex_rd;
  logic          exmem_stall;
  logic          dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [DW-1:0] dmem_req_addr, dmem_req_wdata;
  logic [1:0]    dmem_req_size;
  logic          dmem_resp_valid;
  logic [DW-1:0] dmem_resp_data;
  logic          wb_valid, wb_exc;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic          exc;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_alu_res(ex_alu_res),
    .ex_val_b(ex_val_b), .ex_rd(ex_rd), .flush(flush),
    .exmem_stall(exmem_stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_size(dmem_req_size),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wb(input logic [RW-1:0] rd, input logic [DW-1:0] data, input logic exc);
    wb_exp_t e;
    e.rd = rd; e.data = data; e.exc = exc;
    sb.push_back(e);
  endtask

  // Every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      chk("wb_expected", DW'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        wb_exp_t e;
        e = sb.pop_front();
        chk("wb_rd", DW'(wb_rd), DW'(e.rd));
        chk("wb_data", wb_data, e.data);
        chk("wb_exc", DW'(wb_exc), DW'(e.exc));
      end
    end
  end

  task automatic drive_ex(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                          input logic [DW-1:0] addr, input logic [DW-1:0] wd, input logic [RW-1:0] rd);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_size = sz;
    ex_unsigned = uns; ex_alu_res = addr; ex_val_b = wd; ex_rd = rd;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_size = 2'd0;
    ex_unsigned = 1'b0; ex_alu_res = '0; ex_val_b = '0; ex_rd = '0;
  endtask

  task automatic mem_access(input logic st, input logic [1:0] sz, input logic uns,
                            input logic [DW-1:0] addr, input logic [DW-1:0] wd, input logic [RW-1:0] rd,
                            input int rdy_dly, input logic [DW-1:0] resp, input logic [DW-1:0] exp_data);
    drive_ex(~st, st, sz, uns, addr, wd, rd);
    dmem_req_ready = 1'b0;
    @(negedge clk);
    chk("idle_stall", DW'(exmem_stall), 1);
    chk("idle_no_req", DW'(dmem_req_valid), 0);
    step();
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      chk("bp_req_valid", DW'(dmem_req_valid), 1);
      chk("bp_addr", dmem_req_addr, addr);
      chk("bp_wdata", st ? dmem_req_wdata : '0, st ? wd : '0);
      chk("bp_we", DW'(dmem_req_we), DW'(st));
      chk("bp_stall", DW'(exmem_stall), 1);
      step();
    end
    dmem_req_ready = 1'b1;
    @(negedge clk);
    chk("req_valid", DW'(dmem_req_valid), 1);
    chk("req_addr", dmem_req_addr, addr);
    chk("req_size", DW'(dmem_req_size), DW'(sz));
    chk("req_we", DW'(dmem_req_we), DW'(st));
    step();
    dmem_req_ready = 1'b0;
    @(negedge clk);
    chk("wait_req_dropped", DW'(dmem_req_valid), 0);
    chk("wait_stall", DW'(exmem_stall), 1);
    step();
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = resp;
    push_wb(st ? '0 : rd, st ? '0 : exp_data, 1'b0);
    @(negedge clk);
    chk("resp_stall_release", DW'(exmem_stall), 0);
    step();
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = '0;
    clear_ex();
    step();
    @(negedge clk);
    chk("wb_pending", DW'(sb.size()), 0);
    step();
  endtask

  // Brings an aligned load into WAIT; returns just after the acceptance edge.
  task automatic load_to_wait(input logic [DW-1:0] addr, input logic [RW-1:0] rd);
    drive_ex(1'b1, 1'b0, 2'd3, 1'b0, addr, '0, rd);
    step();
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_data = '0;
    clear_ex();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", DW'(exmem_stall), 0);
    chk("rst_req_valid", DW'(dmem_req_valid), 0);
    chk("rst_req_addr", dmem_req_addr, 0);
    chk("rst_wb_valid", DW'(wb_valid), 0);
    chk("rst_wb_data", wb_data, 0);
    step();
    reset = 1'b1;
    step();

    // Non-memory op.
    drive_ex(1'b0, 1'b0, 2'd0, 1'b0, 64'h1234, '0, 5'd7);
    push_wb(5'd7, 64'h1234, 1'b0);
    @(negedge clk);
    chk("alu_stall", DW'(exmem_stall), 0);
    step();
    clear_ex();
    @(negedge clk);
    chk("alu_stall2", DW'(exmem_stall), 0);
    step();
    @(negedge clk);
    chk("alu_wb_pulse_ends", DW'(wb_valid), 0);
    chk("alu_wb_hold", wb_data, 64'h1234);
    step();

    // Loads of every size and extension, then a backpressured store.
    mem_access(1'b0, 2'd0, 1'b0, 64'h1001, '0, 5'd3, 0, 64'h80, 64'hFFFF_FFFF_FFFF_FF80);
    mem_access(1'b0, 2'd0, 1'b1, 64'h1001, '0, 5'd3, 0, 64'h80, 64'h80);
    mem_access(1'b0, 2'd1, 1'b0, 64'h1002, '0, 5'd4, 1, 64'h5555_8001, 64'hFFFF_FFFF_FFFF_8001);
    mem_access(1'b0, 2'd2, 1'b1, 64'h1004, '0, 5'd5, 0, 64'hAAAA_AAAA_8765_4321, 64'h8765_4321);
    mem_access(1'b0, 2'd2, 1'b0, 64'h1004, '0, 5'd5, 0, 64'hAAAA_AAAA_8765_4321, 64'hFFFF_FFFF_8765_4321);
    mem_access(1'b0, 2'd3, 1'b0, 64'h1008, '0, 5'd6, 2, 64'hF123_4567_89AB_CDEF, 64'hF123_4567_89AB_CDEF);
    mem_access(1'b1, 2'd3, 1'b0, 64'h2000, 64'hCAFE_F00D_DEAD_BEEF, 5'd8, 4, 64'h0, 64'h0);

    // Misaligned accesses never reach memory.
    drive_ex(1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, '0, 5'd9);
    push_wb(5'd9, 64'h1002, 1'b1);
    @(negedge clk);
    chk("mis_w_stall", DW'(exmem_stall), 0);
    step();
    drive_ex(1'b0, 1'b1, 2'd1, 1'b0, 64'h3001, 64'h1, 5'd10);
    push_wb(5'd10, 64'h3001, 1'b1);
    @(negedge clk);
    chk("mis_w_no_req", DW'(dmem_req_valid), 0);
    step();
    drive_ex(1'b1, 1'b0, 2'd3, 1'b0, 64'h1004, '0, 5'd11);
    push_wb(5'd11, 64'h1004, 1'b1);
    @(negedge clk);
    chk("mis_h_no_req", DW'(dmem_req_valid), 0);
    step();
    clear_ex();
    @(negedge clk);
    chk("mis_d_no_req", DW'(dmem_req_valid), 0);
    step();
    @(negedge clk);
    chk("mis_wb_pending", DW'(sb.size()), 0);
    step();

    // Flush in IDLE suppresses writeback and request.
    drive_ex(1'b1, 1'b0, 2'd3, 1'b0, 64'h1000, '0, 5'd12);
    flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", DW'(exmem_stall), 0);
    step();
    flush = 1'b0;
    clear_ex();
    @(negedge clk);
    chk("idle_flush_no_req", DW'(dmem_req_valid), 0);
    step();

    // Flush in WAIT -> DRAIN, response discarded.
    load_to_wait(64'h1000, 5'd4);
    flush = 1'b1;
    clear_ex();
    @(negedge clk);
    chk("wflush_stall", DW'(exmem_stall), 1);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("drain_stall", DW'(exmem_stall), 1);
    step();
    dmem_resp_valid = 1'b1;
    dmem_resp_data = 64'h77;
    @(negedge clk);
    chk("drain_resp_stall", DW'(exmem_stall), 1);
    step();
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    chk("drain_exit_stall", DW'(exmem_stall), 0);
    step();

    // Flush in REQ with ready low: request held, then drained.
    drive_ex(1'b1, 1'b0, 2'd3, 1'b0, 64'h1010, '0, 5'd13);
    step();
    flush = 1'b1;
    clear_ex();
    @(negedge clk);
    chk("rflush_req_held", DW'(dmem_req_valid), 1);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("rflush_req_held2", DW'(dmem_req_valid), 1);
    chk("rflush_addr_held", dmem_req_addr, 64'h1010);
    step();
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    @(negedge clk);
    chk("rflush_drain_req", DW'(dmem_req_valid), 0);
    chk("rflush_drain_stall", DW'(exmem_stall), 1);
    step();
    dmem_resp_valid = 1'b1;
    step();
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    chk("rflush_idle_stall", DW'(exmem_stall), 0);
    step();

    // Flush coinciding with the response.
    load_to_wait(64'h1018, 5'd14);
    dmem_resp_valid = 1'b1;
    flush = 1'b1;
    clear_ex();
    @(negedge clk);
    chk("cflush_stall", DW'(exmem_stall), 0);
    step();
    dmem_resp_valid = 1'b0;
    flush = 1'b0;
    step();

    // Asynchronous reset in WAIT, then a stale response.
    load_to_wait(64'h1020, 5'd15);
    clear_ex();
    #3;
    reset = 1'b0;
    #1;
    chk("arst_stall", DW'(exmem_stall), 0);
    chk("arst_req_valid", DW'(dmem_req_valid), 0);
    chk("arst_req_addr", dmem_req_addr, 0);
    chk("arst_wb_data", wb_data, 0);
    chk("arst_wb_exc", DW'(wb_exc), 0);
    step();
    reset = 1'b1;
    dmem_resp_valid = 1'b1;
    dmem_resp_data = 64'h99;
    @(negedge clk);
    chk("stale_resp_stall", DW'(exmem_stall), 0);
    step();
    dmem_resp_valid = 1'b0;
    step();
    @(negedge clk);
    chk("final_wb_pending", DW'(sb.size()), 0);
    chk("final_wb_data", wb_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
